// File: rtl/dccm_arbiter_if.sv
// ---------------------------------------------------------------------------
// dccm_arbiter_if
//
// Requester-side bundle of the DCCM arbiter: both SRAM-style request ports
// plus their grant and read-return paths.
//
// Signal names carry the arbiter's point of view:
//   *_i : driven by the requesters, sampled by the arbiter
//   *_o : driven by the arbiter, seen by the requesters
//
//   en_i      [1:0]    per-port enable (a disabled port is never granted)
//   req_i     [1:0]    request, port n on bit n
//   we_i      [1:0]    write enable per port
//   addr0_i / addr1_i  word addresses
//   wdata0_i/ wdata1_i write data
//   wmask0_i/ wmask1_i bit-granular write masks
//   gnt_o     [1:0]    grant, one-hot or zero, same cycle as the request
//   rvalid_o  [1:0]    read data valid per port
//   rdata0_o/ rdata1_o read data, zero unless the matching rvalid bit is set
//
// Modports:
//   slave  : the arbiter
//   master : the requesters (or a testbench standing in for them)
// ---------------------------------------------------------------------------
interface dccm_arbiter_if #(
    parameter int Aw = 12,
    parameter int Dw = 32
);
    logic [1:0]    en_i;
    logic [1:0]    req_i;
    logic [1:0]    we_i;
    logic [Aw-1:0] addr0_i;
    logic [Aw-1:0] addr1_i;
    logic [Dw-1:0] wdata0_i;
    logic [Dw-1:0] wdata1_i;
    logic [Dw-1:0] wmask0_i;
    logic [Dw-1:0] wmask1_i;
    logic [1:0]    gnt_o;
    logic [1:0]    rvalid_o;
    logic [Dw-1:0] rdata0_o;
    logic [Dw-1:0] rdata1_o;

    modport slave (
        input  en_i, req_i, we_i,
        input  addr0_i, addr1_i,
        input  wdata0_i, wdata1_i,
        input  wmask0_i, wmask1_i,
        output gnt_o, rvalid_o,
        output rdata0_o, rdata1_o
    );

    modport master (
        output en_i, req_i, we_i,
        output addr0_i, addr1_i,
        output wdata0_i, wdata1_i,
        output wmask0_i, wmask1_i,
        input  gnt_o, rvalid_o,
        input  rdata0_o, rdata1_o
    );
endinterface

// File: rtl/dccm_arbiter.sv
// ---------------------------------------------------------------------------
// dccm_arbiter
//
// Shares the single-ported DFFRAM data memory between two SRAM-style
// requesters. At most one access is granted per cycle using a 1-bit
// round-robin pointer; reads are tracked through a ReadLatency-deep pipe so
// that rvalid/rdata return only to the port that issued the read. The DFFRAM
// has no read-valid of its own, so this block produces it.
//
// Parameters:
//   Aw          word address width
//   Dw          data / write-mask width
//   ReadLatency cycles from a granted read to valid mem_rdata_i (1 or 2)
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   bus          requester bundle (dccm_arbiter_if.slave)
//   mem_req_o    DFFRAM chip enable, forced low while reset is asserted
//   mem_we_o     DFFRAM write strobe
//   mem_addr_o   DFFRAM word address
//   mem_wdata_o  DFFRAM write data
//   mem_wmask_o  DFFRAM bit write mask
//   mem_rdata_i  DFFRAM read data (Do)
// ---------------------------------------------------------------------------
module dccm_arbiter #(
    parameter int Aw          = 12,
    parameter int Dw          = 32,
    parameter int ReadLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    dccm_arbiter_if.slave        bus,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [Aw-1:0]        mem_addr_o,
    output logic [Dw-1:0]        mem_wdata_o,
    output logic [Dw-1:0]        mem_wmask_o,
    input  logic [Dw-1:0]        mem_rdata_i
);

    // Priority pointer: index of the port preferred on contention.
    logic prio_q, prio_d;

    // Read-tracking pipe, stage 0 first, stage ReadLatency-1 is the return.
    logic [ReadLatency-1:0] pipe_vld_q, pipe_vld_d;
    logic [ReadLatency-1:0] pipe_port_q, pipe_port_d;

    logic [1:0] elig;
    logic [1:0] gnt;
    logic       gnt_any;
    logic       gnt_port;
    logic       gnt_we;
    logic [1:0] rvalid;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    assign elig = bus.req_i & bus.en_i;

    always_comb begin
        gnt = 2'b00;
        unique case (elig)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    assign gnt_any  = |gnt;
    assign gnt_port = gnt[1];
    assign gnt_we   = gnt_port ? bus.we_i[1] : bus.we_i[0];

    // After serving port n, prefer the other one next time.
    assign prio_d = gnt_any ? ~gnt_port : prio_q;

    assign bus.gnt_o = gnt;

    // -----------------------------------------------------------------------
    // Memory drive: granted port's fields, or all zero when idle
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (gnt_any) begin
            mem_we_o = gnt_we;
            if (gnt_port) begin
                mem_addr_o  = bus.addr1_i;
                mem_wdata_o = bus.wdata1_i;
                mem_wmask_o = bus.wmask1_i;
            end else begin
                mem_addr_o  = bus.addr0_i;
                mem_wdata_o = bus.wdata0_i;
                mem_wmask_o = bus.wmask0_i;
            end
        end
    end

    // The grant path is purely combinational and may be active during
    // reset; keep the macro disabled until reset is released.
    assign mem_req_o = gnt_any & rst_ni;

    // -----------------------------------------------------------------------
    // Read tracking
    // -----------------------------------------------------------------------
    always_comb begin
        pipe_vld_d     = '0;
        pipe_port_d    = '0;
        pipe_vld_d[0]  = gnt_any & ~gnt_we;
        pipe_port_d[0] = gnt_port;
        for (int i = 1; i < ReadLatency; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_port_d[i] = pipe_port_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q      <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_port_q <= '0;
        end else begin
            prio_q      <= prio_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_port_q <= pipe_port_d;
        end
    end

    // Only one read is issued per cycle, so the last stage can flag at most
    // one port at a time.
    always_comb begin
        rvalid = 2'b00;
        if (pipe_vld_q[ReadLatency-1]) begin
            if (pipe_port_q[ReadLatency-1]) begin
                rvalid = 2'b10;
            end else begin
                rvalid = 2'b01;
            end
        end
    end

    assign bus.rvalid_o = rvalid;
    assign bus.rdata0_o = rvalid[0] ? mem_rdata_i : '0;
    assign bus.rdata1_o = rvalid[1] ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dccm_arbiter.sv
module tb_dccm_arbiter;

    localparam int Aw = 12;
    localparam int Dw = 32;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dccm_arbiter_if #(.Aw(Aw), .Dw(Dw)) bus1 ();
    dccm_arbiter_if #(.Aw(Aw), .Dw(Dw)) bus2 ();

    logic          m1_req, m1_we, m2_req, m2_we;
    logic [Aw-1:0] m1_addr, m2_addr;
    logic [Dw-1:0] m1_wdata, m1_wmask, m2_wdata, m2_wmask;
    logic [Dw-1:0] do1, do2;

    dccm_arbiter #(.Aw(Aw), .Dw(Dw), .ReadLatency(1)) u_dut1 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus1),
        .mem_req_o  (m1_req),
        .mem_we_o   (m1_we),
        .mem_addr_o (m1_addr),
        .mem_wdata_o(m1_wdata),
        .mem_wmask_o(m1_wmask),
        .mem_rdata_i(do1)
    );

    dccm_arbiter #(.Aw(Aw), .Dw(Dw), .ReadLatency(2)) u_dut2 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus2),
        .mem_req_o  (m2_req),
        .mem_we_o   (m2_we),
        .mem_addr_o (m2_addr),
        .mem_wdata_o(m2_wdata),
        .mem_wmask_o(m2_wmask),
        .mem_rdata_i(do2)
    );

    // DFFRAM model driven by the latency-1 instance; both instances see the
    // same stimulus and have identical grant logic, so they share one array.
    // do1 is the macro's Do; do2 adds one register for the latency-2 case.
    bit [Dw-1:0] mem [0:(1<<Aw)-1];
    initial begin
        do1 = '0;
        do2 = '0;
    end
    always @(posedge clk) begin
        if (m1_req && m1_we)
            mem[m1_addr] <= (mem[m1_addr] & ~m1_wmask) | (m1_wdata & m1_wmask);
        if (m1_req && !m1_we)
            do1 <= mem[m1_addr];
        do2 <= do1;
    end

    typedef struct {
        logic          sel;     // 0: check latency-1 instance, 1: latency-2
        logic [1:0]    en, req, we;
        logic [Aw-1:0] a0, a1;
        logic [Dw-1:0] wd0, wd1, wm0, wm1;
        logic [1:0]    gnt, rv;
        logic [Dw-1:0] rd0, rd1;
        logic          mreq, mwe;
        logic [Aw-1:0] maddr;
    } vec_t;

    function automatic vec_t mk(
        input logic sel,
        input logic [1:0] en, input logic [1:0] req, input logic [1:0] we,
        input logic [Aw-1:0] a0, input logic [Aw-1:0] a1,
        input logic [Dw-1:0] wd0, input logic [Dw-1:0] wd1,
        input logic [Dw-1:0] wm0, input logic [Dw-1:0] wm1,
        input logic [1:0] gnt, input logic [1:0] rv,
        input logic [Dw-1:0] rd0, input logic [Dw-1:0] rd1,
        input logic mreq, input logic mwe, input logic [Aw-1:0] maddr);
        vec_t v;
        v.sel = sel; v.en = en; v.req = req; v.we = we;
        v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1; v.wm0 = wm0; v.wm1 = wm1;
        v.gnt = gnt; v.rv = rv; v.rd0 = rd0; v.rd1 = rd1;
        v.mreq = mreq; v.mwe = mwe; v.maddr = maddr;
        return v;
    endfunction

    task automatic drive(
        input logic [1:0] en, input logic [1:0] req, input logic [1:0] we,
        input logic [Aw-1:0] a0, input logic [Aw-1:0] a1,
        input logic [Dw-1:0] wd0, input logic [Dw-1:0] wd1,
        input logic [Dw-1:0] wm0, input logic [Dw-1:0] wm1);
        bus1.en_i = en;  bus1.req_i = req; bus1.we_i = we;
        bus1.addr0_i = a0; bus1.addr1_i = a1;
        bus1.wdata0_i = wd0; bus1.wdata1_i = wd1;
        bus1.wmask0_i = wm0; bus1.wmask1_i = wm1;
        bus2.en_i = en;  bus2.req_i = req; bus2.we_i = we;
        bus2.addr0_i = a0; bus2.addr1_i = a1;
        bus2.wdata0_i = wd0; bus2.wdata1_i = wd1;
        bus2.wmask0_i = wm0; bus2.wmask1_i = wm1;
    endtask

    task automatic idle();
        drive(2'b11, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic chk(input string nm, input logic [Dw-1:0] act, input logic [Dw-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One vector = one clock cycle: drive after the falling edge, sample
    // just before the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v.en, v.req, v.we, v.a0, v.a1, v.wd0, v.wd1, v.wm0, v.wm1);
        #4;
        if (v.sel == 1'b0) begin
            chk({tag, " gnt"},    {30'd0, bus1.gnt_o},    {30'd0, v.gnt});
            chk({tag, " rvalid"}, {30'd0, bus1.rvalid_o}, {30'd0, v.rv});
            chk({tag, " rdata0"}, bus1.rdata0_o, v.rd0);
            chk({tag, " rdata1"}, bus1.rdata1_o, v.rd1);
            chk({tag, " mem_req"}, {31'd0, m1_req}, {31'd0, v.mreq});
            chk({tag, " mem_we"},  {31'd0, m1_we},  {31'd0, v.mwe});
            chk({tag, " mem_addr"}, {20'd0, m1_addr}, {20'd0, v.maddr});
        end else begin
            chk({tag, " gnt"},    {30'd0, bus2.gnt_o},    {30'd0, v.gnt});
            chk({tag, " rvalid"}, {30'd0, bus2.rvalid_o}, {30'd0, v.rv});
            chk({tag, " rdata0"}, bus2.rdata0_o, v.rd0);
            chk({tag, " rdata1"}, bus2.rdata1_o, v.rd1);
            chk({tag, " mem_req"}, {31'd0, m2_req}, {31'd0, v.mreq});
            chk({tag, " mem_we"},  {31'd0, m2_we},  {31'd0, v.mwe});
            chk({tag, " mem_addr"}, {20'd0, m2_addr}, {20'd0, v.maddr});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam logic [Dw-1:0] FM = 32'hFFFF_FFFF;

    initial begin
        vec_t t1[$];
        vec_t t2[$];

        // Latency 1: write/read, byte mask, contention, enable gating,
        // enable drop with a read in flight, write/read mix.
        //            sel en     req    we     a0      a1      wd0           wd1           wm0 wm1              gnt    rv     rd0           rd1           mrq mwe maddr
        t1.push_back(mk(0, 2'b11, 2'b01, 2'b01, 12'h010, 12'h000, 32'hDEADBEEF, 32'h0,        FM, 32'h0,         2'b01, 2'b00, 32'h0,        32'h0,        1, 1, 12'h010));
        t1.push_back(mk(0, 2'b11, 2'b01, 2'b00, 12'h010, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b01, 2'b00, 32'h0,        32'h0,        1, 0, 12'h010));
        t1.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b01, 32'hDEADBEEF, 32'h0,        0, 0, 12'h000));
        t1.push_back(mk(0, 2'b11, 2'b10, 2'b10, 12'h000, 12'h020, 32'h0,        32'h11223344, 0,  FM,            2'b10, 2'b00, 32'h0,        32'h0,        1, 1, 12'h020));
        t1.push_back(mk(0, 2'b11, 2'b10, 2'b10, 12'h000, 12'h020, 32'h0,        32'hAABBCCDD, 0,  32'hFF000000,  2'b10, 2'b00, 32'h0,        32'h0,        1, 1, 12'h020));
        t1.push_back(mk(0, 2'b11, 2'b10, 2'b00, 12'h000, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b10, 2'b00, 32'h0,        32'h0,        1, 0, 12'h020));
        t1.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b10, 32'h0,        32'hAA223344, 0, 0, 12'h000));
        t1.push_back(mk(0, 2'b11, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b01, 2'b00, 32'h0,        32'h0,        1, 0, 12'h010));
        t1.push_back(mk(0, 2'b11, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b10, 2'b01, 32'hDEADBEEF, 32'h0,        1, 0, 12'h020));
        t1.push_back(mk(0, 2'b11, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b01, 2'b10, 32'h0,        32'hAA223344, 1, 0, 12'h010));
        t1.push_back(mk(0, 2'b11, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b10, 2'b01, 32'hDEADBEEF, 32'h0,        1, 0, 12'h020));
        t1.push_back(mk(0, 2'b11, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b01, 2'b10, 32'h0,        32'hAA223344, 1, 0, 12'h010));
        t1.push_back(mk(0, 2'b11, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b10, 2'b01, 32'hDEADBEEF, 32'h0,        1, 0, 12'h020));
        t1.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b10, 32'h0,        32'hAA223344, 0, 0, 12'h000));
        t1.push_back(mk(0, 2'b10, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b10, 2'b00, 32'h0,        32'h0,        1, 0, 12'h020));
        t1.push_back(mk(0, 2'b10, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b10, 2'b10, 32'h0,        32'hAA223344, 1, 0, 12'h020));
        t1.push_back(mk(0, 2'b11, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b01, 2'b10, 32'h0,        32'hAA223344, 1, 0, 12'h010));
        t1.push_back(mk(0, 2'b11, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b10, 2'b01, 32'hDEADBEEF, 32'h0,        1, 0, 12'h020));
        t1.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b10, 32'h0,        32'hAA223344, 0, 0, 12'h000));
        t1.push_back(mk(0, 2'b01, 2'b01, 2'b00, 12'h010, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b01, 2'b00, 32'h0,        32'h0,        1, 0, 12'h010));
        t1.push_back(mk(0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b01, 32'hDEADBEEF, 32'h0,        0, 0, 12'h000));
        t1.push_back(mk(0, 2'b00, 2'b11, 2'b00, 12'h010, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b00, 32'h0,        32'h0,        0, 0, 12'h000));
        t1.push_back(mk(0, 2'b11, 2'b11, 2'b10, 12'h010, 12'h030, 32'h0,        32'hCAFEF00D, 0,  FM,            2'b10, 2'b00, 32'h0,        32'h0,        1, 1, 12'h030));
        t1.push_back(mk(0, 2'b11, 2'b11, 2'b10, 12'h010, 12'h030, 32'h0,        32'hCAFEF00D, 0,  FM,            2'b01, 2'b00, 32'h0,        32'h0,        1, 0, 12'h010));
        t1.push_back(mk(0, 2'b11, 2'b10, 2'b00, 12'h000, 12'h030, 32'h0,        32'h0,        0,  32'h0,         2'b10, 2'b01, 32'hDEADBEEF, 32'h0,        1, 0, 12'h030));
        t1.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b10, 32'h0,        32'hCAFEF00D, 0, 0, 12'h000));

        // Latency 2: pipelined reads, then write followed by reads.
        t2.push_back(mk(1, 2'b11, 2'b01, 2'b00, 12'h010, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b01, 2'b00, 32'h0,        32'h0,        1, 0, 12'h010));
        t2.push_back(mk(1, 2'b11, 2'b10, 2'b00, 12'h000, 12'h020, 32'h0,        32'h0,        0,  32'h0,         2'b10, 2'b00, 32'h0,        32'h0,        1, 0, 12'h020));
        t2.push_back(mk(1, 2'b11, 2'b01, 2'b00, 12'h030, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b01, 2'b01, 32'hDEADBEEF, 32'h0,        1, 0, 12'h030));
        t2.push_back(mk(1, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b10, 32'h0,        32'hAA223344, 0, 0, 12'h000));
        t2.push_back(mk(1, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b01, 32'hCAFEF00D, 32'h0,        0, 0, 12'h000));
        t2.push_back(mk(1, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b00, 32'h0,        32'h0,        0, 0, 12'h000));
        t2.push_back(mk(1, 2'b11, 2'b10, 2'b10, 12'h000, 12'h040, 32'h0,        32'h12345678, 0,  FM,            2'b10, 2'b00, 32'h0,        32'h0,        1, 1, 12'h040));
        t2.push_back(mk(1, 2'b11, 2'b10, 2'b00, 12'h000, 12'h040, 32'h0,        32'h0,        0,  32'h0,         2'b10, 2'b00, 32'h0,        32'h0,        1, 0, 12'h040));
        t2.push_back(mk(1, 2'b11, 2'b01, 2'b00, 12'h040, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b01, 2'b00, 32'h0,        32'h0,        1, 0, 12'h040));
        t2.push_back(mk(1, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b10, 32'h0,        32'h12345678, 0, 0, 12'h000));
        t2.push_back(mk(1, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b01, 32'h12345678, 32'h0,        0, 0, 12'h000));
        t2.push_back(mk(1, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        0,  32'h0,         2'b00, 2'b00, 32'h0,        32'h0,        0, 0, 12'h000));

        // Reset state, with both ports requesting reads.
        rst_n = 1'b0;
        drive(2'b11, 2'b11, 2'b00, 12'h010, 12'h020, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        #4;
        chk("reset rvalid1", {30'd0, bus1.rvalid_o}, 32'd0);
        chk("reset rvalid2", {30'd0, bus2.rvalid_o}, 32'd0);
        chk("reset rdata0",  bus1.rdata0_o, 32'd0);
        chk("reset rdata1",  bus1.rdata1_o, 32'd0);
        chk("reset mem_req1", {31'd0, m1_req}, 32'd0);
        chk("reset mem_req2", {31'd0, m2_req}, 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        for (int i = 0; i < t1.size(); i++)
            apply(t1[i], $sformatf("l1_row%0d", i));

        repeat (3) begin
            @(negedge clk);
            idle();
        end

        // Reset pulsed while a latency-2 read is in flight.
        @(negedge clk);
        drive(2'b11, 2'b01, 2'b00, 12'h010, 12'h000, '0, '0, '0, '0);
        #4;
        chk("rstmid grant", {30'd0, bus2.gnt_o}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(2'b11, 2'b11, 2'b00, 12'h010, 12'h020, '0, '0, '0, '0);
        #4;
        chk("rstmid rvalid2 in reset", {30'd0, bus2.rvalid_o}, 32'd0);
        chk("rstmid rvalid1 cleared",  {30'd0, bus1.rvalid_o}, 32'd0);
        chk("rstmid mem_req gated",    {31'd0, m2_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #4;
        chk("rstmid rvalid2 after release", {30'd0, bus2.rvalid_o}, 32'd0);
        @(negedge clk);
        idle();
        #4;
        chk("rstmid rvalid2 later", {30'd0, bus2.rvalid_o}, 32'd0);
        @(negedge clk);
        drive(2'b11, 2'b11, 2'b00, 12'h010, 12'h020, '0, '0, '0, '0);
        #4;
        chk("rstmid prio gnt2", {30'd0, bus2.gnt_o}, 32'h1);
        chk("rstmid prio gnt1", {30'd0, bus1.gnt_o}, 32'h1);
        repeat (3) begin
            @(negedge clk);
            idle();
        end

        for (int i = 0; i < t2.size(); i++)
            apply(t2[i], $sformatf("l2_row%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dccm_arbiter.md
# dccm_arbiter

Two-port round-robin arbiter that shares the single-ported DFFRAM data memory (DCCM) between two SRAM-style requesters, for example the TL-UL SRAM adapter of the core data bus and a debug/DMA master. It sits between the requesters' `req/we/addr/wdata/wmask` ports and the DFFRAM macro. It grants at most one access per cycle and tracks in-flight reads so that `rvalid`/`rdata` return only to the requester that issued them. It also generates the read-valid that the DFFRAM does not provide.

## Interface
- `Aw`, 12: word address width.
- `Dw`, 32: data width; wmask is bit-granular, same width.
- `ReadLatency`, 1: cycles from granted read to valid `mem_rdata_i`; legal values 1 or 2.

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `en_i` in 2: per-port enable; a port with `en_i[n]=0` is never granted.
- `req_i` in 2: request, port n on bit n.
- `we_i` in 2: write enable per port.
- `addr0_i`, `addr1_i` in Aw: word addresses.
- `wdata0_i`, `wdata1_i` in Dw: write data.
- `wmask0_i`, `wmask1_i` in Dw: bit write masks.
- `gnt_o` out 2: grant, combinational, one-hot or zero.
- `rvalid_o` out 2: read data valid per port, registered.
- `rdata0_o`, `rdata1_o` out Dw: read data; equals `mem_rdata_i` when the matching `rvalid_o` bit is 1, otherwise 0.
- `mem_req_o` out 1: DFFRAM chip enable (EN).
- `mem_we_o` out 1: write strobe.
- `mem_addr_o` out Aw: address.
- `mem_wdata_o` out Dw: write data.
- `mem_wmask_o` out Dw: write mask.
- `mem_rdata_i` in Dw: DFFRAM Do.

## Operation
- Eligible requests: `elig = req_i & en_i`.
- Arbitration is round-robin with a 1-bit priority pointer `prio`. Reset value is 0, meaning port 0 is preferred.
  - If only one port is eligible, that port is granted.
  - If both ports are eligible, port `prio` is granted.
- Pointer update: after any grant to port n, `prio <= ~n`. With no grant, `prio` holds.
- Grant is same-cycle and combinational from `elig` and `prio`. A requester holds `req`, `addr`, `we`, `wdata` and `wmask` stable until it sees `gnt`.
- Memory drive when granted port is g: `mem_req_o=1`, `mem_we_o=we_g`, and the remaining `mem_*` outputs take port g's fields.
- Memory drive with no grant: all `mem_*` outputs are 0.
- Writes return no `rvalid`.
- Read tracking uses a ReadLatency-deep shift pipe of {valid, port}.
  - Stage 0 loads valid = (grant & ~we_g) and port = g.
  - When the last stage is valid, its `rvalid_o[port]` bit is 1.
- Steering: `rdataN_o = rvalid_o[N] ? mem_rdata_i : 0`.
- Throughput: back-to-back reads, writes or mixes of either, one per cycle. Under continuous contention the two ports alternate grants.
- If `en_i` drops while a read is in flight, the read still returns its `rvalid`.

## Timing
- Reset values:
  - `prio=0`.
  - Read pipe fully invalid, so `rvalid_o=0` and `rdata*_o=0`.
  - `gnt_o` and `mem_*` depend combinationally on inputs and may be nonzero during reset. `mem_req_o` is additionally gated by `rst_ni`, so it is 0 while reset is asserted.
- Read latency: a read granted in cycle T has `rvalid_o` in cycle T+ReadLatency, with `rdata` valid in the same cycle.
- Reset asserted mid-operation: the pipe clears asynchronously, in-flight reads are dropped with no `rvalid`, and `prio` returns to 0.
- Simultaneous events:
  - A read return for one port and a new grant to either port in the same cycle are independent.
  - At most one `rvalid_o` bit is set per cycle.
- A write granted in cycle T and a read of the same address granted in T+1 returns the new data, because DFFRAM writes at the edge ending cycle T.

## Test plan
- Single port 0 read:
  - Stimulus: write 0xDEADBEEF to addr 0x010 with full mask, then read addr 0x010 (ReadLatency=1).
  - Response: `gnt_o=01` on both cycles; `rvalid_o=01` exactly one cycle after the read grant; `rdata0_o=0xDEADBEEF`; `rdata1_o=0`.
- Contention:
  - Stimulus: both ports hold read requests for 6 cycles from reset.
  - Response: grant sequence 0,1,0,1,0,1; `rvalid_o` follows the same port order, each one cycle later.
- Byte mask:
  - Stimulus: preload 0x11223344; port 1 writes 0xAABBCCDD with mask 0xFF000000; then read back.
  - Response: `rdata1_o=0xAA223344`; no `rvalid` is produced for the write.
- Enable gating:
  - Stimulus: `en_i=10`, both ports requesting.
  - Response: only port 1 is granted every cycle; port 0 stays ungranted until `en_i[0]` rises, then arbitration alternates.
- Reset mid-read:
  - Stimulus: ReadLatency=2; port 0 read granted; `rst_ni` pulsed low in the next cycle.
  - Response: `rvalid_o` stays 00, and the next contended grant goes to port 0.
- Latency 2 pipelining:
  - Stimulus: ReadLatency=2; reads P0@A, P1@B, P0@C in consecutive cycles.
  - Response: `rvalid_o` = 01, 10, 01 in cycles T+2..T+4, with the matching data on each.
